// File: rtl/seg7_bcd_counter_display.sv
// rtl/seg7_bcd_counter_display.sv - N-digit BCD up/down counter with registered active-low 7-segment outputs; optional overflow blink under SEG7_BLINK_EN
module seg7_bcd_counter_display #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  lzb_en,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg_out
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  logic [4*DIGITS-1:0] load_coerced;
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] count_dec;
  logic                all_nine;
  logic                all_zero;
  logic                carry;
  logic                borrow;
  logic [3:0]          nib;
  logic [3:0]          dig;
  logic [3:0]          sdig;
  logic                leading;

  // Active-low segment code for one BCD digit; anything above 9 shows a dash.
  function automatic logic [6:0] seg7_code(input logic [3:0] d);
    case (d)
      4'd0:    seg7_code = 7'h40;
      4'd1:    seg7_code = 7'h79;
      4'd2:    seg7_code = 7'h24;
      4'd3:    seg7_code = 7'h30;
      4'd4:    seg7_code = 7'h19;
      4'd5:    seg7_code = 7'h12;
      4'd6:    seg7_code = 7'h02;
      4'd7:    seg7_code = 7'h78;
      4'd8:    seg7_code = 7'h00;
      4'd9:    seg7_code = 7'h10;
      default: seg7_code = 7'h3F;
    endcase
  endfunction

  // Ripple increment/decrement candidates, load coercion and the saturation/floor detectors.
  always_comb begin
    load_coerced = '0;
    count_inc    = '0;
    count_dec    = '0;
    all_nine     = 1'b1;
    all_zero     = 1'b1;
    carry        = 1'b1;
    borrow       = 1'b1;
    nib          = '0;
    dig          = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = load_val[4*i +: 4];
      load_coerced[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
      dig = count_q[4*i +: 4];
      if (dig != 4'd9) all_nine = 1'b0;
      if (dig != 4'd0) all_zero = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end else begin
        count_inc[4*i +: 4] = dig;
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        count_dec[4*i +: 4] = dig;
      end
    end
  end

  // Command arbitration: clr beats load beats a lone inc or dec; inc+dec holds.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_coerced;
      ovf_d   = 1'b0;
    end else if (inc && !dec) begin
      if (all_nine) ovf_d = 1'b1;
      else          count_d = count_inc;
    end else if (dec && !inc) begin
      if (!all_zero) count_d = count_dec;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BCW = $clog2(BLINK_DIV + 1);
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;

  // Blink timer restarts on any count reset and on the cycle ovf rises; otherwise runs only while ovf is set.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (clr || load || (ovf_d && !ovf_q)) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (ovf_q) begin
      if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_on_d = 1'b1;
    end
  end

  // Blink state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`endif

  // Segment image of the current count, with leading-zero blanking scanned from the top digit down.
  always_comb begin
    seg_d   = '1;
    leading = 1'b1;
    sdig    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      sdig = count_q[4*i +: 4];
      if (sdig != 4'd0) leading = 1'b0;
      if (lzb_en && leading && (i != 0)) seg_d[7*i +: 7] = 7'h7F;
      else                               seg_d[7*i +: 7] = seg7_code(sdig);
    end
`ifdef SEG7_BLINK_EN
    if (!blink_on_q) seg_d = '1;
`endif
  end

  // Count, overflow flag and segment registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= '1;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign ovf       = ovf_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_seg7_bcd_counter_display.sv
// tb/tb_seg7_bcd_counter_display.sv - scoreboard bench for seg7_bcd_counter_display (DIGITS=4, BLINK_DIV=4)
module tb_seg7_bcd_counter_display;

  localparam int DIGITS    = 4;
  localparam int BLINK_DIV = 4;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        inc;
  logic        dec;
  logic        lzb_en;
  logic [15:0] count_bcd;
  logic        ovf;
  logic [27:0] seg_out;

  seg7_bcd_counter_display #(
    .DIGITS   (DIGITS),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .inc      (inc),
    .dec      (dec),
    .lzb_en   (lzb_en),
    .count_bcd(count_bcd),
    .ovf      (ovf),
    .seg_out  (seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        ovf;
    logic [27:0] seg;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] code_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic [15:0] m_cnt = 16'h0000;
  logic        m_ovf = 1'b0;
  int          m_bcnt = 0;
  bit          m_bon = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    int v = 0;
    for (int k = 3; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] model_seg(input logic [15:0] c, input bit z);
    logic [27:0] s = '1;
    int hn = -1;
    for (int k = 0; k < 4; k++) if (c[4*k +: 4] != 4'd0) hn = k;
    for (int k = 0; k < 4; k++) begin
      if (z && k > hn && k > 0) s[7*k +: 7] = 7'h7F;
      else                      s[7*k +: 7] = code_tbl[c[4*k +: 4]];
    end
    return s;
  endfunction

  // One clock of stimulus: drive, predict, push; then pop and compare after the edge.
  task automatic step(input string tag, input bit r, input bit c, input bit l,
                      input logic [15:0] v, input bit i, input bit d, input bit z);
    exp_t e;
    logic        o;
    logic [15:0] lv;
    rst = r; clr = c; load = l; load_val = v; inc = i; dec = d; lzb_en = z;
    e.tag = tag;
    if (r)          e.seg = '1;
    else if (m_bon) e.seg = model_seg(m_cnt, z);
    else            e.seg = '1;
    o = m_ovf;
    if (r || c) begin
      m_cnt = '0;
      m_ovf = 1'b0;
    end else if (l) begin
      for (int k = 0; k < 4; k++) begin
        lv = v;
        m_cnt[4*k +: 4] = (lv[4*k +: 4] > 4'd9) ? 4'd9 : lv[4*k +: 4];
      end
      m_ovf = 1'b0;
    end else if (i && !d) begin
      if (bcd2int(m_cnt) == 9999) m_ovf = 1'b1;
      else                        m_cnt = int2bcd(bcd2int(m_cnt) + 1);
    end else if (d && !i) begin
      if (bcd2int(m_cnt) != 0) m_cnt = int2bcd(bcd2int(m_cnt) - 1);
    end
`ifdef SEG7_BLINK_EN
    if (r || c || l || (m_ovf && !o)) begin
      m_bcnt = 0;
      m_bon  = 1'b1;
    end else if (o) begin
      if (m_bcnt == BLINK_DIV - 1) begin
        m_bcnt = 0;
        m_bon  = !m_bon;
      end else begin
        m_bcnt++;
      end
    end else begin
      m_bon = 1'b1;
    end
`endif
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_cnt"}, 32'(count_bcd), 32'(e.cnt));
      chk({e.tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
      chk({e.tag, "_seg"}, 32'(seg_out), 32'(e.seg));
    end
  endtask

  initial begin
    logic [15:0] rv;
    int          op;
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; inc = 1'b0; dec = 1'b0; lzb_en = 1'b0;

    step("reset", 1, 0, 0, 16'h0, 0, 0, 0);
    chk("reset_cnt_lit", 32'(count_bcd), 32'h0000);
    chk("reset_ovf_lit", 32'(ovf), 32'h0);
    chk("reset_seg_lit", 32'(seg_out), 32'h0FFFFFFF);
    step("idle0", 0, 0, 0, 16'h0, 0, 0, 0);
    chk("zero_seg_lit", 32'(seg_out), 32'({4{7'h40}}));

    step("ld0199", 0, 0, 1, 16'h0199, 0, 0, 1);
    step("carry", 0, 0, 0, 16'h0, 1, 0, 1);
    chk("carry_cnt_lit", 32'(count_bcd), 32'h0200);
    step("carry_w", 0, 0, 0, 16'h0, 0, 0, 1);
    chk("carry_seg_lit", 32'(seg_out), 32'({7'h7F, 7'h24, 7'h40, 7'h40}));

    step("ld9999", 0, 0, 1, 16'h9999, 0, 0, 0);
    step("sat1", 0, 0, 0, 16'h0, 1, 0, 0);
    step("sat2", 0, 0, 0, 16'h0, 1, 0, 0);
    chk("sat_cnt_lit", 32'(count_bcd), 32'h9999);
    chk("sat_ovf_lit", 32'(ovf), 32'h1);
    step("clr", 0, 1, 0, 16'h0, 0, 0, 0);
    chk("clr_cnt_lit", 32'(count_bcd), 32'h0000);
    chk("clr_ovf_lit", 32'(ovf), 32'h0);

    step("ld1000", 0, 0, 1, 16'h1000, 0, 0, 1);
    step("borrow", 0, 0, 0, 16'h0, 0, 1, 1);
    chk("borrow_cnt_lit", 32'(count_bcd), 32'h0999);
    step("clr2", 0, 1, 0, 16'h0, 0, 0, 1);
    step("floor", 0, 0, 0, 16'h0, 0, 1, 1);
    chk("floor_cnt_lit", 32'(count_bcd), 32'h0000);
    chk("floor_ovf_lit", 32'(ovf), 32'h0);

    step("ld0005", 0, 0, 1, 16'h0005, 0, 0, 0);
    step("incdec", 0, 0, 0, 16'h0, 1, 1, 0);
    chk("incdec_cnt_lit", 32'(count_bcd), 32'h0005);
    step("ld_inc", 0, 0, 1, 16'h0042, 1, 0, 0);
    chk("ldinc_cnt_lit", 32'(count_bcd), 32'h0042);
    step("ld_coerce", 0, 0, 1, 16'hAB3F, 0, 0, 1);
    chk("coerce_cnt_lit", 32'(count_bcd), 32'h9939);
    step("clr_ld", 0, 1, 1, 16'h1234, 1, 0, 1);
    step("lzb_idle", 0, 0, 0, 16'h0, 0, 0, 1);
    chk("lzb_zero_seg_lit", 32'(seg_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      rv = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rv = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0001;
      case (op)
        0:       step("rnd_clr", 0, 1, 0, rv, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        1, 2:    step("rnd_ld", 0, 0, 1, rv, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        default: step("rnd_cnt", 0, 0, 0, rv, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      endcase
    end

`ifdef SEG7_BLINK_EN
    step("bl_ld", 0, 0, 1, 16'h9999, 0, 0, 0);
    step("bl_ovf", 0, 0, 0, 16'h0, 1, 0, 0);
    for (int n = 0; n < 18; n++) step("blink", 0, 0, 0, 16'h0, 0, 0, 0);
    step("bl_rst", 1, 0, 0, 16'h0, 0, 0, 0);
    chk("bl_rst_seg_lit", 32'(seg_out), 32'h0FFFFFFF);
    for (int n = 0; n < 10; n++) begin
      step("post_rst", 0, 0, 0, 16'h0, 0, 0, 0);
      chk("post_rst_seg_lit", 32'(seg_out), 32'({4{7'h40}}));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
